// File: rtl/collision_checker.sv
// collision_checker: on a frame tick, snapshots the ten obstacle slots and the
// player lane/jump state, then walks the snapshot one slot per clock looking
// for an overlap with the player sprite. The first hit latches a sticky
// collision flag along with the slot index and lane that caused it.
module collision_checker #(
  parameter int         PLAYER_X   = 100,
  parameter int         PLAYER_W   = 32,
  parameter int         OBSTACLE_W = 32,
  parameter logic [3:0] JUMPABLE   = 4'b0011
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         game_reset,
  input  logic         frame_tick,
  input  logic [159:0] obstacles_in,
  input  logic [1:0]   player_lane,
  input  logic         player_jump,
  output logic         busy,
  output logic         scan_done,
  output logic         collision_out,
  output logic [3:0]   hit_index,
  output logic [1:0]   hit_lane,
  output logic         overrun
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] LAST_SLOT = 4'd9;

  // Overlap window on the obstacle's right edge, widened to 12 bits so a
  // position near 2047 can never wrap into the window.
  localparam logic [11:0] HIT_LO = 12'(PLAYER_X);
  localparam logic [11:0] HIT_HI = 12'(PLAYER_X + PLAYER_W + OBSTACLE_W);

  logic [1:0]        state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [9:0][15:0]  snapObs_q, snapObs_d;
  logic [1:0]        snapLane_q, snapLane_d;
  logic              snapJump_q, snapJump_d;
  logic              busy_q, busy_d;
  logic              scanDone_q, scanDone_d;
  logic              collision_q, collision_d;
  logic [3:0]        hitIndex_q, hitIndex_d;
  logic [1:0]        hitLane_q, hitLane_d;
  logic              overrun_q, overrun_d;

  logic [15:0]       curSlot;
  logic [1:0]        curType;
  logic [10:0]       curPos;
  logic [11:0]       curPosExt;
  logic [1:0]        curLane;
  logic              curActive;
  logic              curJumpCleared;
  logic              curInWindow;
  logic              curHit;

  // Decode the snapshot slot currently under the scan pointer and decide
  // whether it overlaps the player, honouring the jump-clearable sprite mask.
  always_comb begin
    curSlot        = snapObs_q[idx_q];
    curType        = curSlot[15:14];
    curPos         = curSlot[13:3];
    curLane        = curSlot[2:1];
    curActive      = curSlot[0];
    curPosExt      = {1'b0, curPos};
    curInWindow    = (curPosExt > HIT_LO) && (curPosExt < HIT_HI);
    curJumpCleared = snapJump_q && JUMPABLE[curType];
    curHit         = curActive && (curLane == snapLane_q) && curInWindow &&
                     !curJumpCleared;
  end

  // Next-state logic for the scan sequencer, the snapshot and the sticky
  // hit record; ticks that arrive mid-scan are dropped and only flagged.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snapObs_d   = snapObs_q;
    snapLane_d  = snapLane_q;
    snapJump_d  = snapJump_q;
    busy_d      = busy_q;
    scanDone_d  = 1'b0;
    collision_d = collision_q;
    hitIndex_d  = hitIndex_q;
    hitLane_d   = hitLane_q;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          snapObs_d  = obstacles_in;
          snapLane_d = player_lane;
          snapJump_d = player_jump;
          idx_d      = 4'd0;
          busy_d     = 1'b1;
          state_d    = SCAN;
        end
      end

      SCAN: begin
        overrun_d = frame_tick;
        if (curHit && !collision_q) begin
          collision_d = 1'b1;
          hitIndex_d  = idx_q;
          hitLane_d   = curLane;
        end
        if (idx_q == LAST_SLOT) begin
          scanDone_d = 1'b1;
          state_d    = DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      DONE: begin
        overrun_d = frame_tick;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; either reset source wipes the scan, snapshot and hit
  // record and takes precedence over a coincident frame tick.
  always_ff @(posedge clk_in) begin
    if (rst_in || game_reset) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      snapObs_q   <= '0;
      snapLane_q  <= 2'd0;
      snapJump_q  <= 1'b0;
      busy_q      <= 1'b0;
      scanDone_q  <= 1'b0;
      collision_q <= 1'b0;
      hitIndex_q  <= 4'd0;
      hitLane_q   <= 2'd0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snapObs_q   <= snapObs_d;
      snapLane_q  <= snapLane_d;
      snapJump_q  <= snapJump_d;
      busy_q      <= busy_d;
      scanDone_q  <= scanDone_d;
      collision_q <= collision_d;
      hitIndex_q  <= hitIndex_d;
      hitLane_q   <= hitLane_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy          = busy_q;
  assign scan_done     = scanDone_q;
  assign collision_out = collision_q;
  assign hit_index     = hitIndex_q;
  assign hit_lane      = hitLane_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_collision_checker.sv
// Directed testbench for collision_checker. Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_collision_checker;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         game_reset;
  logic         frame_tick;
  logic [159:0] obstacles_in;
  logic [1:0]   player_lane;
  logic         player_jump;
  logic         busy;
  logic         scan_done;
  logic         collision_out;
  logic [3:0]   hit_index;
  logic [1:0]   hit_lane;
  logic         overrun;

  int checks   = 0;
  int failures = 0;

  logic [159:0] obsHit3;
  logic [159:0] obsJump3;
  logic [159:0] obsPrio;
  logic [159:0] obsLater;
  int           doneCount;

  collision_checker dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .game_reset    (game_reset),
    .frame_tick    (frame_tick),
    .obstacles_in  (obstacles_in),
    .player_lane   (player_lane),
    .player_jump   (player_jump),
    .busy          (busy),
    .scan_done     (scan_done),
    .collision_out (collision_out),
    .hit_index     (hit_index),
    .hit_lane      (hit_lane),
    .overrun       (overrun)
  );

  // 10 ns free-running system clock
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] mkObs(input logic [1:0] sprite,
                                        input logic [10:0] pos,
                                        input logic [1:0] lane);
    return {sprite, pos, lane, 1'b1};
  endfunction

  function automatic logic [159:0] placeSlot(input logic [159:0] base,
                                             input int slot,
                                             input logic [15:0] o);
    logic [159:0] r;
    r = base;
    r[slot*16 +: 16] = o;
    return r;
  endfunction

  // Pulse frame_tick for one cycle; returns in the cycle after edge E0.
  task automatic applyStimulus(input logic [159:0] obs, input logic [1:0] lane,
                               input logic jump);
    obstacles_in = obs;
    player_lane  = lane;
    player_jump  = jump;
    frame_tick   = 1'b1;
    @(negedge clk_in);
    frame_tick   = 1'b0;
  endtask

  // From the cycle after E0, advance to the first IDLE cycle after DONE.
  task automatic finishScan();
    repeat (11) @(negedge clk_in);
  endtask

  task automatic doGameReset();
    game_reset = 1'b1;
    @(negedge clk_in);
    game_reset = 1'b0;
  endtask

  task automatic runCase(input string tag, input logic [159:0] obs,
                         input logic [1:0] lane, input logic jump,
                         input int expColl, input int expIdx, input int expLane);
    doGameReset();
    applyStimulus(obs, lane, jump);
    finishScan();
    checkOutput({tag, "_coll"}, 32'(collision_out), expColl);
    checkOutput({tag, "_idx"}, 32'(hit_index), expIdx);
    checkOutput({tag, "_lane"}, 32'(hit_lane), expLane);
  endtask

  initial begin
    rst_in       = 1'b1;
    game_reset   = 1'b0;
    frame_tick   = 1'b0;
    obstacles_in = '0;
    player_lane  = 2'd0;
    player_jump  = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;

    // Reset state
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(scan_done), 0);
    checkOutput("rst_coll", 32'(collision_out), 0);
    checkOutput("rst_idx", 32'(hit_index), 0);
    checkOutput("rst_lane", 32'(hit_lane), 0);
    checkOutput("rst_overrun", 32'(overrun), 0);

    // Empty scan: busy for 11 cycles, scan_done in the cycle after E0+10
    applyStimulus('0, 2'd0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      checkOutput($sformatf("empty_busy_%0d", k), 32'(busy), 32'(k <= 10));
      checkOutput($sformatf("empty_done_%0d", k), 32'(scan_done), 32'(k == 10));
      @(negedge clk_in);
    end
    checkOutput("empty_coll", 32'(collision_out), 0);

    // Slot 3 hit, visible only after edge E0+4
    obsHit3 = placeSlot('0, 3, mkObs(2'd2, 11'd120, 2'd1));
    doGameReset();
    applyStimulus(obsHit3, 2'd1, 1'b0);
    repeat (3) @(negedge clk_in);
    checkOutput("slot3_before", 32'(collision_out), 0);
    @(negedge clk_in);
    checkOutput("slot3_coll", 32'(collision_out), 1);
    checkOutput("slot3_idx", 32'(hit_index), 3);
    checkOutput("slot3_lane", 32'(hit_lane), 1);
    repeat (7) @(negedge clk_in);

    // Lane and jump rules
    runCase("lane_miss", obsHit3, 2'd2, 1'b0, 0, 0, 0);
    obsJump3 = placeSlot('0, 3, mkObs(2'd0, 11'd120, 2'd1));
    runCase("jump_clear", obsJump3, 2'd1, 1'b1, 0, 0, 0);
    runCase("jump_nocl", obsHit3, 2'd1, 1'b1, 1, 3, 1);

    // Horizontal window boundaries (hit range 101..163)
    runCase("pos100", placeSlot('0, 0, mkObs(2'd3, 11'd100, 2'd2)), 2'd2, 1'b0, 0, 0, 0);
    runCase("pos101", placeSlot('0, 0, mkObs(2'd3, 11'd101, 2'd2)), 2'd2, 1'b0, 1, 0, 2);
    runCase("pos163", placeSlot('0, 0, mkObs(2'd3, 11'd163, 2'd2)), 2'd2, 1'b0, 1, 0, 2);
    runCase("pos164", placeSlot('0, 0, mkObs(2'd3, 11'd164, 2'd2)), 2'd2, 1'b0, 0, 0, 0);
    runCase("pos2047", placeSlot('0, 0, mkObs(2'd3, 11'd2047, 2'd2)), 2'd2, 1'b0, 0, 0, 0);

    // Lowest index wins, later scans do not overwrite, game_reset clears
    obsPrio = placeSlot(placeSlot('0, 2, mkObs(2'd1, 11'd130, 2'd3)),
                        7, mkObs(2'd2, 11'd140, 2'd3));
    runCase("prio", obsPrio, 2'd3, 1'b0, 1, 2, 3);
    obsLater = placeSlot('0, 5, mkObs(2'd2, 11'd110, 2'd3));
    applyStimulus(obsLater, 2'd3, 1'b0);
    finishScan();
    checkOutput("sticky_coll", 32'(collision_out), 1);
    checkOutput("sticky_idx", 32'(hit_index), 2);
    doGameReset();
    checkOutput("greset_coll", 32'(collision_out), 0);
    checkOutput("greset_idx", 32'(hit_index), 0);
    checkOutput("greset_lane", 32'(hit_lane), 0);

    // Second tick 5 cycles after the first: one overrun pulse, one scan_done
    applyStimulus('0, 2'd0, 1'b0);
    repeat (4) @(negedge clk_in);
    frame_tick = 1'b1;
    @(negedge clk_in);
    frame_tick = 1'b0;
    checkOutput("ovr_pulse", 32'(overrun), 1);
    @(negedge clk_in);
    checkOutput("ovr_pulse_end", 32'(overrun), 0);
    doneCount = 0;
    for (int i = 0; i < 20; i++) begin
      if (scan_done) doneCount++;
      @(negedge clk_in);
    end
    checkOutput("ovr_done_count", 32'(doneCount), 1);
    checkOutput("ovr_busy_end", 32'(busy), 0);

    // Tick in DONE is dropped; tick in the following IDLE cycle is taken
    doGameReset();
    applyStimulus('0, 2'd0, 1'b0);
    repeat (10) @(negedge clk_in);
    checkOutput("done_cycle", 32'(scan_done), 1);
    frame_tick = 1'b1;
    @(negedge clk_in);
    checkOutput("done_tick_busy", 32'(busy), 0);
    checkOutput("done_tick_ovr", 32'(overrun), 1);
    @(negedge clk_in);
    frame_tick = 1'b0;
    checkOutput("idle_tick_busy", 32'(busy), 1);
    checkOutput("idle_tick_ovr", 32'(overrun), 0);
    finishScan();

    // Live input change mid-scan only affects the next scan
    doGameReset();
    applyStimulus('0, 2'd1, 1'b0);
    repeat (2) @(negedge clk_in);
    obstacles_in = placeSlot('0, 8, mkObs(2'd2, 11'd150, 2'd1));
    repeat (9) @(negedge clk_in);
    checkOutput("midscan_coll", 32'(collision_out), 0);
    applyStimulus(obstacles_in, 2'd1, 1'b0);
    finishScan();
    checkOutput("nextscan_coll", 32'(collision_out), 1);
    checkOutput("nextscan_idx", 32'(hit_index), 8);

    // game_reset during a scan aborts it with no scan_done
    doGameReset();
    applyStimulus(obsHit3, 2'd1, 1'b0);
    repeat (3) @(negedge clk_in);
    game_reset = 1'b1;
    @(negedge clk_in);
    game_reset = 1'b0;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_coll", 32'(collision_out), 0);
    doneCount = 0;
    for (int i = 0; i < 14; i++) begin
      if (scan_done) doneCount++;
      @(negedge clk_in);
    end
    checkOutput("abort_done_count", 32'(doneCount), 0);

    // Reset and tick together: reset wins, no scan starts
    game_reset = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk_in);
    game_reset = 1'b0;
    frame_tick = 1'b0;
    checkOutput("rst_tick_busy0", 32'(busy), 0);
    @(negedge clk_in);
    checkOutput("rst_tick_busy1", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/collision_checker.md
# collision_checker

Consumes the per-frame obstacle list published by the obstacle generator plus the forwarded player lane/jump state, and decides whether the player has hit an obstacle. On each frame tick it snapshots all ten obstacle slots and the player state, then scans one slot per clock. It raises a sticky collision flag that the game FSM uses to end the run.

## Interface
Parameters:
- PLAYER_X, 100: left edge of the player sprite, in screen pixels.
- PLAYER_W, 32: player sprite width, in pixels.
- OBSTACLE_W, 32: obstacle width, in pixels.
- JUMPABLE, 4'b0011: bit k set means sprite_type k is cleared by a jump.

Ports:
- clk_in, in, 1: system clock.
- rst_in, in, 1: reset. Synchronous, active-high.
- game_reset, in, 1: synchronous clear of game state. Same effect as rst_in on this block.
- frame_tick, in, 1: one-cycle pulse that requests a scan.
- obstacles_in, in, obstacle [9:0]: slot array. Each slot is a 16-bit packed obstacle: sprite_type[15:14], position[13:3], lane[2:1], active[0]. position is the obstacle's right edge.
- player_lane, in, 2: current player lane.
- player_jump, in, 1: player is airborne.
- busy, out, 1: scan in progress.
- scan_done, out, 1: one-cycle pulse at the end of every completed scan.
- collision_out, out, 1: sticky hit flag.
- hit_index, out, 4: slot that first set collision_out.
- hit_lane, out, 2: lane of that slot.
- overrun, out, 1: one-cycle pulse when a frame_tick arrives while busy.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE with frame_tick=1:
  - capture obstacles_in (160 bits), player_lane and player_jump into snapshot registers;
  - idx <= 0; go to SCAN.
- SCAN: evaluate snapshot slot idx in this cycle.
  - If idx==9, go to DONE; otherwise idx <= idx+1.
- DONE: scan_done=1 for one cycle, then return to IDLE.
- Hit condition for slot i, using snapshot values only. All of the following must hold:
  - active==1;
  - lane==snap_lane;
  - position > PLAYER_X;
  - position < PLAYER_X + PLAYER_W + OBSTACLE_W.
- Compare in 12-bit unsigned arithmetic: zero-extend position and the parameter sums, so there is no wrap at 2047.
- Jump rule: if snap_jump==1 and JUMPABLE[sprite_type]==1, the slot is not a hit.
- First hit in a scan while collision_out==0:
  - collision_out <= 1;
  - hit_index <= idx;
  - hit_lane <= lane.
- Later hits in the same scan or in later scans change none of these outputs. The lowest index wins.
- collision_out stays 1 until rst_in or game_reset. Scanning continues regardless of collision_out.
- frame_tick in SCAN or DONE:
  - the tick is dropped and no scan is queued;
  - overrun=1 on the next cycle.
- rst_in or game_reset, in any state, takes priority over all other events:
  - state <= IDLE; the scan is aborted and no scan_done is produced;
  - all outputs are cleared, and snapshot registers are cleared.
- Live obstacles_in changes during a scan have no effect on that scan's result.

## Timing
- Reset values: busy=0, scan_done=0, collision_out=0, hit_index=0, hit_lane=0, overrun=0, state=IDLE, idx=0.
- For frame_tick sampled high at edge E0:
  - busy=1 from after E0 through the DONE cycle; slot i is evaluated in the cycle after edge E0+i;
  - collision_out, if set by slot i, is visible after edge E0+i+1;
  - scan_done is high in the cycle after E0+10;
  - IDLE is re-entered after E0+11.
- Scan latency is 11 cycles. Minimum tick spacing for no overrun is 12 cycles. A 60 Hz frame rate never overruns.
- busy and scan_done are registered outputs. Nothing is combinational from input to output.
- A frame_tick in the DONE cycle is dropped and flagged with overrun. A frame_tick in the first IDLE cycle after DONE is accepted.
- game_reset and frame_tick high in the same cycle: reset wins and no scan starts.

## Test plan
- All slots inactive, frame_tick: scan_done exactly 11 cycles after the tick; collision_out=0; busy high for 11 cycles.
- Slot 3: active, lane 1, position 120, sprite 2. player_lane=1, jump=0. Result: collision_out=1, hit_index=3, hit_lane=1 after the edge E0+4.
- Same stimulus with player_lane=2: no collision. Same stimulus with sprite 0 and jump=1: no collision. Sprite 2 with jump=1: collision.
- Boundaries, lane matched, using defaults (hit range is 101..163):
  - position 100 → no hit;
  - position 101 → hit;
  - position 163 → hit;
  - position 164 → no hit;
  - position 2047 → no hit (no wrap).
- Slots 2 and 7 both hit: hit_index=2. A later scan with only slot 5 hitting leaves hit_index=2. game_reset then clears collision_out and hit_index to 0.
- Second frame_tick 5 cycles after the first: overrun pulse, one scan_done only. Separately, obstacles_in is changed mid-scan to a hitting slot: no collision until the next scan. game_reset at cycle 4 of a scan: no scan_done, busy=0 next cycle.
